sync_fifo_fwft: RTL
===================

Name: sync_fifo_fwft

Overview:
- Single-clock BRAM FIFO that succeeds the current single- and dual-clock FIFO blocks.
- Generalised in width and depth, with a selectable read mode: STANDARD (pop, then data on the next cycle) or FWFT (first-word-fall-through, head word always presented).
- Adds occupancy count, programmable almost-full/almost-empty flags, sticky overflow/underflow flags and synchronous flush.
- Used as the generic buffering element between AXI-stream front-ends and processing cores in one clock domain.

Parameters:
- FIFO_DW, 16, data width in bits.
- FIFO_AW, 8, address width; capacity DEPTH = 2**FIFO_AW words, all usable.
- RD_MODE, "STANDARD", read mode: "STANDARD" or "FWFT".
- AFULL_TH, 2**FIFO_AW-4, afull_o asserts when count >= AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 4, aempty_o asserts when count <= AEMPTY_TH; must be < AFULL_TH.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous, active-high reset.
- flush_i  in  1  synchronous clear of contents.
- push_i  in  1  write request.
- data_i  in  FIFO_DW  write data.
- pop_i  in  1  read request (STANDARD) or head acknowledge (FWFT).
- data_o  out  FIFO_DW  read data.
- valid_o  out  1  data_o qualifier.
- empty_o  out  1  empty flag.
- full_o  out  1  full flag.
- afull_o  out  1  almost full.
- aempty_o  out  1  almost empty.
- count_o  out  FIFO_AW+1  words held, including the FWFT head register.
- clr_err_i  in  1  clears ovf_o and udf_o.
- ovf_o  out  1  sticky: push rejected.
- udf_o  out  1  sticky: pop rejected.

Behaviour:
- Reset (rst_i high, asynchronous):
  - pointers, count_o, valid_o, data_o, ovf_o, udf_o = 0
  - empty_o = 1, aempty_o = 1, full_o = 0, afull_o = 0
- Pointers are FIFO_AW+1 bits wide; the extra MSB distinguishes full from empty.
- Wrap-around is natural modulo 2**(FIFO_AW+1).
- Storage is a RAM with a 1-cycle registered read port. No combinational RAM read path.
- Push accepted iff push_i & !full_o; the word is written at wr_ptr and wr_ptr increments.
- Push with full_o = 1 is dropped and sets ovf_o, even if a pop is accepted in the same cycle.
- All flags are registered and updated on the same edge as count_o:
  - full_o = (count == DEPTH)
  - afull_o = (count >= AFULL_TH)
  - aempty_o = (count <= AEMPTY_TH)
- Accepted push and accepted pop in the same cycle: count_o unchanged.
- STANDARD mode:
  - empty_o = (count == 0).
  - Pop accepted iff pop_i & !empty_o. The RAM read is issued at rd_ptr and rd_ptr increments.
  - data_o is valid after the next edge; valid_o pulses for exactly 1 cycle per accepted pop. data_o holds its value otherwise.
  - Pop with empty_o = 1 sets udf_o, including when a push occurs in the same cycle.
- FWFT mode:
  - The RAM output register is the head register. A prefetch is issued whenever (!valid_o | accepted pop) and RAM holds unread words.
  - Latency: word pushed into an empty FIFO at edge N gives valid_o = 1 after edge N+1.
  - empty_o = !valid_o. Pop accepted iff pop_i & valid_o.
  - Back-to-back pops sustain 1 word per cycle while words remain.
  - pop_i with valid_o = 0 sets udf_o.
- Flush (flush_i at an edge):
  - pointers and count_o cleared; valid_o = 0; flags return to reset values.
  - push/pop in the same cycle are ignored and do not set error flags.
  - data_o is not cleared; ovf_o and udf_o are preserved.
- clr_err_i clears ovf_o and udf_o. If a new error occurs in the same cycle, set wins.
- rst_i mid-operation discards all contents immediately.

Test Plan:
- STANDARD, FIFO_AW=3:
  - push 0x11..0x88 (8 words) -> full_o=1, count_o=8, afull_o=1 at count 4.
  - 9th push -> ovf_o=1, count stays 8.
  - 8 pops -> data_o 0x11..0x88, each one cycle after its pop; then empty_o=1.
- FWFT, FIFO_AW=3:
  - single push 0xA5 at edge N -> valid_o=1, data_o=0xA5 after edge N+1.
  - pop -> valid_o=0, empty_o=1, count_o=0.
- FWFT, streaming: continuous push and pop for 100 cycles with 4 words preloaded -> count_o stays 4, output sequence in order, no gaps.
- Simultaneous push+pop on empty (STANDARD) -> push accepted, udf_o=1, count_o=1. Then clr_err_i -> udf_o=0.
- Wrap-around: push 20 / pop 20 interleaved on DEPTH=8 -> data intact, count_o returns to 0.
- Flush and reset:
  - flush_i with 5 words held plus push -> count_o=0, empty_o=1, ovf_o unchanged.
  - rst_i pulse mid-stream -> all outputs at reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/sync_fifo_fwft.sv
// Single-clock FIFO built on a registered-read RAM. It has a STANDARD read mode
// (pop, then data on the next cycle) and an FWFT read mode, plus level flags and sticky error flags.
module sync_fifo_fwft #(
  parameter int    FIFO_DW   = 16,
  parameter int    FIFO_AW   = 8,
  parameter string RD_MODE   = "STANDARD",
  parameter int    AFULL_TH  = 2**FIFO_AW - 4,
  parameter int    AEMPTY_TH = 4
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               push_i,
  input  logic [FIFO_DW-1:0] data_i,
  input  logic               pop_i,
  output logic [FIFO_DW-1:0] data_o,
  output logic               valid_o,
  output logic               empty_o,
  output logic               full_o,
  output logic               afull_o,
  output logic               aempty_o,
  output logic [FIFO_AW:0]   count_o,
  input  logic               clr_err_i,
  output logic               ovf_o,
  output logic               udf_o
);

  localparam int DEPTH   = 2**FIFO_AW;
  localparam bit IS_FWFT = (RD_MODE == "FWFT");

  localparam logic [FIFO_AW:0] DEPTH_C  = (FIFO_AW+1)'(DEPTH);
  localparam logic [FIFO_AW:0] AFULL_C  = (FIFO_AW+1)'(AFULL_TH);
  localparam logic [FIFO_AW:0] AEMPTY_C = (FIFO_AW+1)'(AEMPTY_TH);
  localparam logic [FIFO_AW:0] ONE_C    = {{FIFO_AW{1'b0}}, 1'b1};

  logic [FIFO_DW-1:0] mem [DEPTH];
  logic [FIFO_DW-1:0] ram_rd_q;

  logic [FIFO_AW:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0] count_q, count_d;
  logic             valid_q, valid_d;
  logic             empty_q, empty_d;
  logic             full_q, full_d;
  logic             afull_q, afull_d;
  logic             aempty_q, aempty_d;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             seen_q, seen_d;

  logic push_acc;
  logic pop_acc;
  logic rd_en;
  logic ram_avail;
  logic ovf_set;
  logic udf_set;

  // RAM array with a write port and a registered read port. It has no reset,
  // so the tools can map it onto block RAM.
  always_ff @(posedge clk_i) begin
    if (push_acc) begin
      mem[wr_ptr_q[FIFO_AW-1:0]] <= data_i;
    end
    if (rd_en) begin
      ram_rd_q <= mem[rd_ptr_q[FIFO_AW-1:0]];
    end
  end

  always_comb begin
    push_acc  = push_i & ~full_q & ~flush_i;
    ram_avail = (wr_ptr_q != rd_ptr_q);
    if (IS_FWFT) begin
      pop_acc = pop_i & valid_q & ~flush_i;
      // Refill the head register whenever it is empty or being consumed
      rd_en   = (~valid_q | pop_acc) & ram_avail & ~flush_i;
    end else begin
      pop_acc = pop_i & ~empty_q & ~flush_i;
      rd_en   = pop_acc;
    end
    ovf_set = push_i & full_q & ~flush_i;
    udf_set = pop_i & empty_q & ~flush_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    valid_d  = valid_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      valid_d  = 1'b0;
    end else begin
      if (push_acc) begin
        wr_ptr_d = wr_ptr_q + ONE_C;
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + ONE_C;
      end
      case ({push_acc, pop_acc})
        2'b10:   count_d = count_q + ONE_C;
        2'b01:   count_d = count_q - ONE_C;
        default: count_d = count_q;
      endcase
      if (IS_FWFT) begin
        valid_d = rd_en | (valid_q & ~pop_acc);
      end else begin
        valid_d = rd_en;
      end
    end

    full_d   = (count_d == DEPTH_C);
    afull_d  = (count_d >= AFULL_C);
    aempty_d = (count_d <= AEMPTY_C);
    if (IS_FWFT) begin
      empty_d = ~valid_d;
    end else begin
      empty_d = (count_d == '0);
    end

    // A new error in this cycle wins over clr_err_i
    ovf_d  = ovf_set | (ovf_q & ~clr_err_i);
    udf_d  = udf_set | (udf_q & ~clr_err_i);
    seen_d = seen_q | rd_en;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      valid_q  <= 1'b0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
      seen_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      valid_q  <= valid_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
      seen_q   <= seen_d;
    end
  end

  // The RAM read register cannot be reset, so data_o reads as zero until
  // the first read after reset has loaded the register.
  assign data_o   = seen_q ? ram_rd_q : '0;
  assign valid_o  = valid_q;
  assign empty_o  = empty_q;
  assign full_o   = full_q;
  assign afull_o  = afull_q;
  assign aempty_o = aempty_q;
  assign count_o  = count_q;
  assign ovf_o    = ovf_q;
  assign udf_o    = udf_q;

endmodule
